// File: rtl/hqm_rcfwl_gclk_pccdu_mdop_if.sv
// Divisor-programming port of the pccdu DOP driver: 4-phase req, one-cycle ack qualified by err.
// Requester holds ch/val stable while req is high and drops req only after ack.
interface hqm_rcfwl_gclk_pccdu_mdop_if #(
  parameter int DIV_W = 4,
  parameter int CH_W  = 2
);
  logic             cfg_div_req;
  logic [CH_W-1:0]  cfg_div_ch;
  logic [DIV_W-1:0] cfg_div_val;
  logic             cfg_div_ack;
  logic             cfg_div_err;

  modport master (output cfg_div_req, cfg_div_ch, cfg_div_val, input cfg_div_ack, cfg_div_err);
  modport slave  (input cfg_div_req, cfg_div_ch, cfg_div_val, output cfg_div_ack, cfg_div_err);
endinterface

// File: rtl/hqm_rcfwl_gclk_pccdu_mdop.sv
// Multi-channel DOP clock driver: per-channel programmable dividers with free and gated+scan outputs.
// Outputs decode flops only; divisor changes ack at the next period boundary, req held until ack.
module hqm_rcfwl_gclk_pccdu_mdop #(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 4,
  parameter int RESET_DIV = 2,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                             fdop_preclk_grid,
  input  logic                             fdop_rst_b,
  input  logic                             fdop_preclk_div_sync,
  input  logic                             fscan_clk,
  input  logic [NUM_CH-1:0]                fscan_dop_clken,
  hqm_rcfwl_gclk_pccdu_mdop_if.slave       cfg,
  output logic [NUM_CH-1:0]                adop_postclk_free,
  output logic [NUM_CH-1:0]                adop_postclk
);

  typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;

  localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);
  localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(RESET_DIV);

  state_t            state_q, state_d;
  logic              err_q, err_d;
  logic              accept, ack_pend, req_legal;
  logic [NUM_CH-1:0] sel, pend, bnd;

  assign req_legal = ({1'b0, cfg.cfg_div_ch} < NUM_CH_L) && (cfg.cfg_div_val >= DIV_W'(2));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, div_q, pdiv_q;
    logic             gate_q, pend_q;
    logic [DIV_W:0]   hi;

    assign hi       = ({1'b0, div_q} + 1'b1) >> 1;
    assign bnd[g]   = (cnt_q == div_q - 1'b1);
    assign pend[g]  = pend_q;
    assign sel[g]   = (cfg.cfg_div_ch == CH_W'(g));
    assign adop_postclk_free[g] = ({1'b0, cnt_q} < hi);
    assign adop_postclk[g]      = (adop_postclk_free[g] & gate_q) | fscan_clk;

    // Boundary is always a low cycle, so re-sampling the gate here never clips a pulse.
    always_ff @(posedge fdop_preclk_grid) begin
      if (!fdop_rst_b) begin
        cnt_q  <= RST_DIV - 1'b1;
        div_q  <= RST_DIV;
        pdiv_q <= RST_DIV;
        gate_q <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        if (bnd[g]) gate_q <= fscan_dop_clken[g];
        if (fdop_preclk_div_sync) begin
          cnt_q <= div_q - 1'b1;
        end else if (bnd[g] && pend_q) begin
          div_q  <= pdiv_q;
          cnt_q  <= '0;
          pend_q <= 1'b0;
        end else if (bnd[g]) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        if (accept && sel[g]) begin
          pend_q <= 1'b1;
          pdiv_q <= cfg.cfg_div_val;
        end
      end
    end
  end

  always_ff @(posedge fdop_preclk_grid) begin
    if (!fdop_rst_b) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Sync overrides the boundary, so the pending divisor lands one cycle later.
  always_comb begin
    state_d  = state_q;
    err_d    = 1'b0;
    accept   = 1'b0;
    ack_pend = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg.cfg_div_req) begin
          if (req_legal) begin
            accept  = 1'b1;
            state_d = PEND;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      PEND: begin
        if ((|(sel & pend & bnd)) && !fdop_preclk_div_sync) begin
          ack_pend = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!cfg.cfg_div_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg.cfg_div_ack = fdop_rst_b & (ack_pend | err_q);
  assign cfg.cfg_div_err = fdop_rst_b & err_q;

endmodule

// File: tb/tb_hqm_rcfwl_gclk_pccdu_mdop.sv
// Bench for the pccdu DOP driver: per-cycle expected outputs queued at drive time and checked at negedge,
// plus per-scenario timing checks derived from the clocking behaviour.
module tb_hqm_rcfwl_gclk_pccdu_mdop;
  localparam int N  = 5;
  localparam int DW = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic [N-1:0] free;
    logic [N-1:0] post;
    logic         ack;
    logic         err;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst_b, sync, scan;
  logic [N-1:0] clken;
  logic [N-1:0] free_o, post_o;

  hqm_rcfwl_gclk_pccdu_mdop_if #(.DIV_W(DW), .CH_W(CW)) cfg_if ();

  hqm_rcfwl_gclk_pccdu_mdop #(.NUM_CH(N), .DIV_W(DW), .RESET_DIV(2)) dut (
    .fdop_preclk_grid     (clk),
    .fdop_rst_b           (rst_b),
    .fdop_preclk_div_sync (sync),
    .fscan_clk            (scan),
    .fscan_dop_clken      (clken),
    .cfg                  (cfg_if),
    .adop_postclk_free    (free_o),
    .adop_postclk         (post_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  obs_t sb_q[$];
  logic [N-1:0] s_free, s_post, ack_free;
  logic s_ack, s_err;

  // Reference model: a channel is high while 2*cnt < div (i.e. the first ceil(div/2) cycles).
  int m_cnt[N], m_div[N], m_pend[N], m_pdiv[N], m_gate[N];
  int m_st;
  bit m_errq;

  function automatic obs_t model_out();
    obs_t o;
    int c;
    o = '0;
    for (int i = 0; i < N; i++) begin
      o.free[i] = (2 * m_cnt[i] < m_div[i]);
      o.post[i] = (o.free[i] & (m_gate[i] != 0)) | scan;
    end
    c = int'(cfg_if.cfg_div_ch);
    o.err = rst_b & m_errq;
    o.ack = rst_b & (m_errq | (m_st == 1 && c < N && m_pend[c] != 0 &&
                               m_cnt[c] == m_div[c] - 1 && !sync));
    return o;
  endfunction

  always @(posedge clk) begin : mdl
    int  c;
    bit  legal, hit, acc;
    if (!rst_b) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] <= 1; m_div[i] <= 2; m_pend[i] <= 0; m_pdiv[i] <= 2; m_gate[i] <= 0;
      end
      m_st <= 0; m_errq <= 0;
    end else begin
      c     = int'(cfg_if.cfg_div_ch);
      legal = (c < N) && (cfg_if.cfg_div_val >= 2);
      hit   = (m_st == 1) && (c < N) && (m_pend[c] != 0) && (m_cnt[c] == m_div[c] - 1) && !sync;
      acc   = 0;
      m_errq <= 0;
      case (m_st)
        0: if (cfg_if.cfg_div_req) begin
             if (legal) begin m_st <= 1; acc = 1; end
             else begin m_st <= 2; m_errq <= 1; end
           end
        1: if (hit) m_st <= 2;
        default: if (!cfg_if.cfg_div_req) m_st <= 0;
      endcase
      for (int i = 0; i < N; i++) begin
        if (m_cnt[i] == m_div[i] - 1) m_gate[i] <= clken[i];
        if (sync) m_cnt[i] <= m_div[i] - 1;
        else if (m_cnt[i] == m_div[i] - 1 && m_pend[i] != 0) begin
          m_div[i] <= m_pdiv[i]; m_cnt[i] <= 0; m_pend[i] <= 0;
        end else if (m_cnt[i] == m_div[i] - 1) m_cnt[i] <= 0;
        else m_cnt[i] <= m_cnt[i] + 1;
        if (acc && i == c) begin m_pend[i] <= 1; m_pdiv[i] <= int'(cfg_if.cfg_div_val); end
      end
    end
  end

  always @(negedge clk) begin
    obs_t e, g;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = '{free: free_o, post: post_o, ack: cfg_if.cfg_div_ack, err: cfg_if.cfg_div_err};
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL sb t=%0t free=%b/%b post=%b/%b ack=%b/%b err=%b/%b (got/exp)",
                 $time, g.free, e.free, g.post, e.post, g.ack, e.ack, g.err, e.err);
      end
    end
  end

  task automatic cyc();
    sb_q.push_back(model_out());
    @(negedge clk);
    s_free = free_o; s_post = post_o; s_ack = cfg_if.cfg_div_ack; s_err = cfg_if.cfg_div_err;
    @(posedge clk); #1;
  endtask

  task automatic do_req(input int ch, input int val, output int lat, output bit ackd, output bit errd);
    cfg_if.cfg_div_ch  = CW'(ch);
    cfg_if.cfg_div_val = DW'(val);
    cfg_if.cfg_div_req = 1'b1;
    lat = -1; ackd = 0; errd = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (s_ack === 1'b1) begin lat = k; ackd = 1; errd = s_err; ack_free = s_free; break; end
    end
    if (!ackd) begin
      n_vec++; n_err++;
      $display("FAIL req_timeout ch=%0d val=%0d no ack within 40 cycles", ch, val);
    end
    cfg_if.cfg_div_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    bit [4:0] ef;
    rst_b = 0; sync = 0; scan = 0; clken = '1;
    cfg_if.cfg_div_req = 0; cfg_if.cfg_div_ch = '0; cfg_if.cfg_div_val = '0;
    @(posedge clk); #1; @(posedge clk); #1;
    cyc();
    n_vec++; if (s_free !== 5'h00 || s_post !== 5'h00 || s_ack !== 1'b0 || s_err !== 1'b0) begin
      n_err++; $display("FAIL reset_state free=%b post=%b ack=%b err=%b exp 0", s_free, s_post, s_ack, s_err);
    end
    scan = 1; cyc();
    n_vec++; if (s_post !== 5'h1F) begin n_err++; $display("FAIL reset_scan post=%b exp 11111", s_post); end
    scan = 0; rst_b = 1;
    ef = 5'b01010;
    for (int k = 0; k < 5; k++) begin
      cyc();
      n_vec++;
      if (s_free !== {N{ef[k]}} || s_post !== {N{ef[k]}}) begin
        n_err++; $display("FAIL reset_release k=%0d free=%b post=%b exp %b", k, s_free, s_post, {N{ef[k]}});
      end
    end
  endtask

  task automatic test_program();
    int lat; bit a, e;
    int chs[3] = '{1, 2, 3};
    int vals[3] = '{3, 4, 7};
    for (int j = 0; j < 3; j++) begin
      do_req(chs[j], vals[j], lat, a, e);
      n_vec++;
      if (a && (e || lat < 1 || lat > 2)) begin
        n_err++; $display("FAIL program ch=%0d err=%b lat=%0d exp err=0 lat 1..2", chs[j], e, lat);
      end
    end
  endtask

  task automatic test_sync();
    bit [5:0] e3;
    repeat (5) cyc();
    sync = 1; cyc(); sync = 0;
    cyc();
    n_vec++; if (s_free !== 5'h00) begin n_err++; $display("FAIL sync_t1 free=%b exp 00000", s_free); end
    cyc();
    n_vec++; if (s_free !== 5'h1F) begin n_err++; $display("FAIL sync_t2 free=%b exp 11111", s_free); end
    e3 = 6'b000111;
    for (int k = 0; k < 6; k++) begin
      cyc();
      n_vec++;
      if (s_free[3] !== e3[k]) begin n_err++; $display("FAIL sync_div7 k=%0d got=%b exp=%b", k, s_free[3], e3[k]); end
    end
  endtask

  task automatic test_gate();
    bit prev, found;
    prev = s_free[2]; found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc();
      if (!prev && s_free[2]) found = 1;
      prev = s_free[2];
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL gate_align no rising edge on ch2 within 20 cycles"); end
    clken[2] = 0;
    cyc();
    n_vec++; if (s_post[2] !== 1'b1) begin n_err++; $display("FAIL gate_complete post2=%b exp 1", s_post[2]); end
    cyc(); cyc();
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_vec++;
      if (s_free[2] !== 1'b1 || s_post[2] !== 1'b0) begin
        n_err++; $display("FAIL gate_suppress k=%0d free2=%b post2=%b exp 1/0", k, s_free[2], s_post[2]);
      end
    end
    scan = 1; cyc();
    n_vec++; if (s_post !== 5'h1F) begin n_err++; $display("FAIL scan_or post=%b exp 11111", s_post); end
    scan = 0; clken[2] = 1;
    repeat (8) cyc();
  endtask

  task automatic test_sync_pend();
    bit [2:0] e2;
    sync = 1; cyc(); sync = 0; cyc();
    cfg_if.cfg_div_ch = 3'd2; cfg_if.cfg_div_val = 4'd3; cfg_if.cfg_div_req = 1;
    cyc();
    sync = 1; cyc(); sync = 0;
    n_vec++; if (s_ack !== 1'b0) begin n_err++; $display("FAIL syncpend_t ack=%b exp 0", s_ack); end
    cyc();
    n_vec++; if (s_ack !== 1'b1 || s_err !== 1'b0) begin
      n_err++; $display("FAIL syncpend_t1 ack=%b err=%b exp 1/0", s_ack, s_err);
    end
    cfg_if.cfg_div_req = 0;
    e2 = 3'b011;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_vec++;
      if (s_free[2] !== e2[k]) begin n_err++; $display("FAIL syncpend_div3 k=%0d got=%b exp=%b", k, s_free[2], e2[k]); end
    end
  endtask

  task automatic test_div_change();
    bit prev, found;
    int lat, highs0; bit a, e;
    bit [9:0] e1;
    prev = s_free[1]; found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc();
      if (!prev && s_free[1]) found = 1;
      prev = s_free[1];
    end
    do_req(1, 5, lat, a, e);
    n_vec++;
    if (!found || e || lat != 1 || ack_free[1] !== 1'b0) begin
      n_err++; $display("FAIL divchg_ack found=%b err=%b lat=%0d free1=%b exp 1/0/1/0", found, e, lat, ack_free[1]);
    end
    e1 = 10'b0011100111;
    highs0 = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc();
      highs0 += int'(s_free[0]);
      n_vec++;
      if (s_free[1] !== e1[k]) begin n_err++; $display("FAIL divchg_div5 k=%0d got=%b exp=%b", k, s_free[1], e1[k]); end
    end
    n_vec++; if (highs0 != 5) begin n_err++; $display("FAIL divchg_ch0 highs=%0d exp 5", highs0); end
  endtask

  task automatic test_err();
    int chs[2] = '{1, 5};
    int vals[2] = '{1, 3};
    for (int j = 0; j < 2; j++) begin
      cfg_if.cfg_div_ch = CW'(chs[j]); cfg_if.cfg_div_val = DW'(vals[j]); cfg_if.cfg_div_req = 1;
      cyc();
      n_vec++; if (s_ack !== 1'b0) begin n_err++; $display("FAIL err_accept j=%0d ack=%b exp 0", j, s_ack); end
      cyc();
      n_vec++; if (s_ack !== 1'b1 || s_err !== 1'b1) begin
        n_err++; $display("FAIL err_ack j=%0d ack=%b err=%b exp 1/1", j, s_ack, s_err);
      end
      for (int k = 0; k < 4; k++) begin
        cyc();
        n_vec++; if (s_ack !== 1'b0) begin n_err++; $display("FAIL err_hold j=%0d k=%0d ack=%b exp 0", j, k, s_ack); end
      end
      cfg_if.cfg_div_req = 0; cyc(); cyc();
    end
  endtask

  task automatic test_reset_pend();
    int lat; bit a, e;
    bit [3:0] er;
    sync = 1; cyc(); sync = 0; cyc();
    cfg_if.cfg_div_ch = 3'd3; cfg_if.cfg_div_val = 4'd5; cfg_if.cfg_div_req = 1;
    cyc(); cyc();
    rst_b = 0; cfg_if.cfg_div_req = 0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_vec++; if (s_ack !== 1'b0) begin n_err++; $display("FAIL rstpend_ack k=%0d ack=%b exp 0", k, s_ack); end
    end
    rst_b = 1;
    er = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_vec++; if (s_free[3] !== er[k]) begin n_err++; $display("FAIL rstpend_div2 k=%0d got=%b exp=%b", k, s_free[3], er[k]); end
    end
    do_req(3, 5, lat, a, e);
    n_vec++;
    if (a && (e || lat < 1 || lat > 2)) begin n_err++; $display("FAIL rstpend_req err=%b lat=%0d exp 0, 1..2", e, lat); end
    repeat (12) cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_program();
    test_sync();
    test_gate();
    test_sync_pend();
    test_div_change();
    test_err();
    test_reset_pend();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
